fir_out_buffer: RTL and testbench
=================================

Name: fir_out_buffer

Overview:
Downstream stage of the 5-tap shift-add FIR filter. Takes the filter's free-running 10-bit output and an input-side sample-valid. Realigns that valid to the filter's 2-cycle latency and discards outputs whose 5-sample history contains any invalid sample. Buffers good results in a FIFO with a ready/valid interface, so a stalling consumer (bus bridge, capture RAM) can drain them.

Parameters:
DATA_W, 10, width of the filter output word
LAT, 2, clock cycles from the filter's x input to its dataout
TAPS, 5, filter taps; an output is valid only after TAPS consecutive valid inputs
DEPTH, 16, FIFO entries (power of 2)

Ports:
clk  in  1  clock; everything on posedge
rst  in  1  synchronous, active-high reset
in_valid  in  1  high in the same cycle the filter's x input carries a real sample
din  in  DATA_W  filter dataout
out_data  out  DATA_W  FIFO head word
out_valid  out  1  FIFO non-empty
out_ready  in  1  consumer accepts out_data this cycle
count  out  $clog2(DEPTH)+1  FIFO occupancy
overflow  out  1  sticky: a good result was dropped because the FIFO was full

Behaviour:
- Reset (rst=1 at posedge): valid delay line, run counter and FIFO pointers are cleared. count=0, out_valid=0, out_data=0, overflow=0. Mid-operation reset discards all FIFO contents and history. The run counter restarts from zero.
- Valid alignment: in_valid passes through a LAT-stage shift register. av = stage LAT-1, which is aligned with din.
- Run counter run, range 0..TAPS-1, saturating:
  - av=0: run <= 0, nothing pushed.
  - av=1, run<TAPS-1: run <= run+1, din dropped (warm-up).
  - av=1, run==TAPS-1: push din; run holds.
  - Result: the first TAPS-1 aligned valids after reset or after any gap are dropped. Every later consecutive valid is pushed.
- FIFO: first-word-fall-through. out_data shows the head combinationally from storage. out_valid = (count != 0).
- Pop occurs when out_valid && out_ready. Holding out_ready=1 on an empty FIFO has no effect.
- Push when full:
  - Accepted if a pop happens in the same cycle; count is unchanged.
  - Otherwise dropped, and overflow <= 1. overflow clears only on rst.
- Push and pop in the same cycle on a non-full, non-empty FIFO: count is unchanged.
- Push into an empty FIFO: word appears on out_data with out_valid=1 the next cycle. No same-cycle bypass.
- Pointers wrap modulo DEPTH. count is a separate counter, 0..DEPTH inclusive.
- No arithmetic is applied to din; it is stored bit-exact.

Optional Feature:
FIR_OUT_PEAK_EN
- Defined: adds output port peak [DATA_W-1:0], reset 0. peak <= max(peak, din) on every accepted push. Adds input peak_clr (1 bit); peak_clr=1 sets peak <= 0 next edge and takes priority over a same-cycle update.
- Undefined: neither port exists and no peak logic is built.

Decomposition:
- Shared package fir_pkg:
  - FIR_DATA_W=10, FIR_IN_W=8, FIR_TAPS=5, FIR_LAT=2.
  - typedef fir_out_t (logic [FIR_DATA_W-1:0]).
  - These are also the source for the filter's own widths.
- One sub-module, sync_fifo_fwft: parameters DATA_W and DEPTH; ports push, pop, full, empty, count. It is reusable elsewhere.
- Alignment, run counter and overflow logic stay in fir_out_buffer.

Test Plan:
- Reset then idle: rst for 3 cycles -> count=0, out_valid=0, overflow=0. out_ready toggling has no effect.
- Warm-up: 8 consecutive in_valid with din model = 62 (x=64 constant), out_ready=1 -> exactly 4 words of 62 out. The first appears on out_valid LAT+TAPS cycles after the first in_valid.
- Gap restart: valids 1..6, in_valid=0 for 1 cycle, then 6 more -> 2 words, then 2 words. The 4 aligned valids following the gap are dropped.
- Backpressure/full: out_ready=0, 25 consecutive valids -> count saturates at 16, overflow=1, extra 5 words lost. Release out_ready -> first 16 pushed words drain in order.
- Full with simultaneous push/pop: FIFO at 16, out_ready=1 while pushing -> count stays 16, overflow stays 0, data order preserved.
- Mid-stream reset: rst for 1 cycle with count=7 -> count=0, out_valid=0 next cycle. The next 4 aligned valids are dropped. With FIR_OUT_PEAK_EN, peak returns to 0.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared widths and timing of the 5-tap shift-add FIR filter and its output buffer.
package fir_pkg;
    localparam int FIR_DATA_W = 10;
    localparam int FIR_IN_W   = 8;
    localparam int FIR_TAPS   = 5;
    localparam int FIR_LAT    = 2;

    typedef logic [FIR_DATA_W-1:0] fir_out_t;
endpackage

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO; head word is read combinationally from storage.
module sync_fifo_fwft #(
    parameter int DATA_W = 10,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     pop,
    output logic [DATA_W-1:0]        rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO still takes a word when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/fir_out_buffer.sv
// FIR output buffer: realigns sample-valid, drops warm-up outputs, queues good words.
// Optional peak tracker (peak, peak_clr ports) built when FIR_OUT_PEAK_EN is defined.
module fir_out_buffer
    import fir_pkg::*;
#(
    parameter int DATA_W = FIR_DATA_W,
    parameter int LAT    = FIR_LAT,
    parameter int TAPS   = FIR_TAPS,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        din,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
`ifdef FIR_OUT_PEAK_EN
    ,
    output logic [DATA_W-1:0]        peak,
    input  logic                     peak_clr
`endif
);
    localparam int RUN_W = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(TAPS - 1);

    logic [LAT-1:0]   vsr;
    logic             av;
    logic [RUN_W-1:0] run;
    logic             push_req;
    logic             pop_now;
    logic             full;
    logic             empty;

    assign av       = vsr[LAT-1];
    assign push_req = av && (run == RUN_MAX);
    assign pop_now  = out_valid && out_ready;
    assign out_valid = !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            vsr      <= '0;
            run      <= '0;
            overflow <= 1'b0;
        end else begin
            vsr <= (vsr << 1) | LAT'(in_valid);
            // run saturates at TAPS-1 once the history window is fully valid
            if (!av) begin
                run <= '0;
            end else if (run != RUN_MAX) begin
                run <= run + 1'b1;
            end
            if (push_req && full && !pop_now) begin
                overflow <= 1'b1;
            end
        end
    end

    sync_fifo_fwft #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .wdata (din),
        .pop   (out_ready),
        .rdata (out_data),
        .full  (full),
        .empty (empty),
        .count (count)
    );

`ifdef FIR_OUT_PEAK_EN
    logic push_acc;

    assign push_acc = push_req && (!full || pop_now);

    always_ff @(posedge clk) begin
        if (rst || peak_clr) begin
            peak <= '0;
        end else if (push_acc && (din > peak)) begin
            peak <= din;
        end
    end
`endif
endmodule

// File: tb/tb_fir_out_buffer.sv
// Scoreboard bench for fir_out_buffer: inputs driven and outputs sampled on the falling edge.
module tb_fir_out_buffer;
    import fir_pkg::*;

    localparam int DEPTH = 16;
    localparam int TAPS  = FIR_TAPS;
    localparam int LAT   = FIR_LAT;
    localparam int DW    = FIR_DATA_W;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [DW-1:0] din;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] count;
    logic          overflow;
`ifdef FIR_OUT_PEAK_EN
    logic [DW-1:0] peak;
    logic          peak_clr;
    logic [DW-1:0] peak_m;
`endif

    always #5 clk = ~clk;

    fir_out_buffer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .din       (din),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .overflow  (overflow)
`ifdef FIR_OUT_PEAK_EN
        ,
        .peak      (peak),
        .peak_clr  (peak_clr)
`endif
    );

    int            tests = 0;
    int            fails = 0;
    int            got   = 0;
    int            cons  = 0;
    bit            ovf_m = 1'b0;
    logic [DW-1:0] sb [$];
    logic          dly_good [LAT];
    logic [DW-1:0] dly_val  [LAT];

    task automatic model_clear();
        sb.delete();
        ovf_m = 1'b0;
        cons  = 0;
        for (int k = 0; k < LAT; k++) begin
            dly_good[k] = 1'b0;
            dly_val[k]  = '0;
        end
`ifdef FIR_OUT_PEAK_EN
        peak_m = '0;
`endif
    endtask

    // Called at a falling edge: check outputs against the model, drive the next inputs,
    // advance the model by one rising edge, then wait for the next falling edge.
    task automatic cycle(input logic v, input logic [DW-1:0] val, input logic rdy, input logic r);
        int size_before;
        bit pop_m;
        tests++;
        if (count !== CW'(sb.size())) begin
            fails++;
            $display("FAIL sb_count: got %0d expected %0d", count, sb.size());
        end
        tests++;
        if (out_valid !== (sb.size() != 0)) begin
            fails++;
            $display("FAIL sb_out_valid: got %b expected %b", out_valid, sb.size() != 0);
        end
        tests++;
        if (overflow !== ovf_m) begin
            fails++;
            $display("FAIL sb_overflow: got %b expected %b", overflow, ovf_m);
        end
        if (sb.size() != 0) begin
            tests++;
            if (out_data !== sb[0]) begin
                fails++;
                $display("FAIL sb_data: got %0d expected %0d", out_data, sb[0]);
            end
        end
`ifdef FIR_OUT_PEAK_EN
        tests++;
        if (peak !== peak_m) begin
            fails++;
            $display("FAIL sb_peak: got %0d expected %0d", peak, peak_m);
        end
`endif
        rst       = r;
        in_valid  = v;
        out_ready = rdy;
        din       = dly_val[LAT-1];
        if (r) begin
            model_clear();
        end else begin
            size_before = sb.size();
            pop_m = rdy && (size_before != 0);
            if (pop_m) begin
                void'(sb.pop_front());
                got++;
            end
            if (dly_good[LAT-1]) begin
                if (size_before < DEPTH || pop_m) begin
                    sb.push_back(dly_val[LAT-1]);
`ifdef FIR_OUT_PEAK_EN
                    if (dly_val[LAT-1] > peak_m) peak_m = dly_val[LAT-1];
`endif
                end else begin
                    ovf_m = 1'b1;
                end
            end
            for (int k = LAT - 1; k > 0; k--) begin
                dly_good[k] = dly_good[k-1];
                dly_val[k]  = dly_val[k-1];
            end
            cons = v ? cons + 1 : 0;
            dly_good[0] = v && (cons >= TAPS);
            dly_val[0]  = v ? val : DW'(10'h3FF);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        cycle(1'b0, '0, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        din = '0;
        out_ready = 1'b0;
`ifdef FIR_OUT_PEAK_EN
        peak_clr = 1'b0;
`endif
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if (count !== '0 || out_valid !== 1'b0 || overflow !== 1'b0 || out_data !== '0) begin
            fails++;
            $display("FAIL reset_state: count=%0d out_valid=%b overflow=%b out_data=%0d expected all 0",
                     count, out_valid, overflow, out_data);
        end
        for (int i = 0; i < 6; i++) cycle(1'b0, '0, logic'(i % 2), 1'b0);
        tests++;
        if (count !== '0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL idle_ready_toggle: count=%0d out_valid=%b expected 0 0", count, out_valid);
        end
    endtask

    task automatic test_warmup();
        int first = -1;
        int g0;
        do_reset();
        g0 = got;
        for (int i = 0; i < 20; i++) begin
            if (first < 0 && out_valid === 1'b1) first = i;
            cycle(i < 8, DW'(62), 1'b1, 1'b0);
        end
        tests++;
        if (first != LAT + TAPS) begin
            fails++;
            $display("FAIL warmup_latency: got %0d cycles expected %0d", first, LAT + TAPS);
        end
        tests++;
        if (got - g0 != 4) begin
            fails++;
            $display("FAIL warmup_words: got %0d expected 4", got - g0);
        end
    endtask

    task automatic test_gap();
        int g0;
        do_reset();
        g0 = got;
        for (int i = 0; i < 25; i++) cycle((i < 13) && (i != 6), DW'(100 + i), 1'b1, 1'b0);
        tests++;
        if (got - g0 != 4) begin
            fails++;
            $display("FAIL gap_words: got %0d expected 4", got - g0);
        end
    endtask

    task automatic test_full();
        int g0;
        do_reset();
        g0 = got;
        for (int i = 0; i < 31; i++) cycle(i < 25, DW'(200 + i), 1'b0, 1'b0);
        tests++;
        if (count !== CW'(16) || overflow !== 1'b1) begin
            fails++;
            $display("FAIL full_saturate: count=%0d overflow=%b expected 16 1", count, overflow);
        end
        for (int i = 0; i < 20; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        tests++;
        if (got - g0 != 16 || count !== '0 || overflow !== 1'b1) begin
            fails++;
            $display("FAIL full_drain: words=%0d count=%0d overflow=%b expected 16 0 1",
                     got - g0, count, overflow);
        end
    endtask

    task automatic test_full_pushpop();
        int g0;
        do_reset();
        g0 = got;
        for (int i = 0; i < 34; i++) begin
            if (i >= 22 && i <= 32) begin
                tests++;
                if (count !== CW'(16) || overflow !== 1'b0) begin
                    fails++;
                    $display("FAIL pushpop_full: step %0d count=%0d overflow=%b expected 16 0",
                             i, count, overflow);
                end
            end
            cycle(i < 30, DW'(300 + i), i >= 22, 1'b0);
        end
        for (int i = 0; i < 20; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        tests++;
        if (got - g0 != 26) begin
            fails++;
            $display("FAIL pushpop_words: got %0d expected 26", got - g0);
        end
    endtask

    task automatic test_midreset();
        int g0;
        do_reset();
        for (int i = 0; i < 13; i++) cycle(i < 11, DW'(400 + i), 1'b0, 1'b0);
        tests++;
        if (count !== CW'(7)) begin
            fails++;
            $display("FAIL midreset_fill: count=%0d expected 7", count);
        end
`ifdef FIR_OUT_PEAK_EN
        tests++;
        if (peak !== DW'(410)) begin
            fails++;
            $display("FAIL peak_track: got %0d expected 410", peak);
        end
`endif
        cycle(1'b0, '0, 1'b0, 1'b1);
        tests++;
        if (count !== '0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL midreset_clear: count=%0d out_valid=%b expected 0 0", count, out_valid);
        end
`ifdef FIR_OUT_PEAK_EN
        tests++;
        if (peak !== '0) begin
            fails++;
            $display("FAIL peak_reset: got %0d expected 0", peak);
        end
`endif
        g0 = got;
        for (int i = 0; i < 16; i++) cycle(i < 6, DW'(500 + i), 1'b1, 1'b0);
        tests++;
        if (got - g0 != 2) begin
            fails++;
            $display("FAIL midreset_warmup: got %0d words expected 2", got - g0);
        end
    endtask

    initial begin
        test_reset();
        test_warmup();
        test_gap();
        test_full();
        test_full_pushpop();
        test_midreset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
